// File: rtl/oric_clk_pkg.sv
// Shared state encoding and default divider ratios for the Oric clock/reset sequencer.
package oric_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } clkseq_state_t;

  localparam int PIX_DIV_DEF = 4;
  localparam int CPU_DIV_DEF = 24;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level into clk.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/oric_clk_reset_seq.sv
// Post-PLL sequencer: waits for stable lock, holds the core in reset with enables
// running, then releases it; generates the pixel and two-phase CPU clock enables.
module oric_clk_reset_seq
  import oric_clk_pkg::*;
#(
  parameter int PIX_DIV       = PIX_DIV_DEF,
  parameter int CPU_DIV       = CPU_DIV_DEF,
  parameter int SETTLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 64
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic soft_reset,
  output logic core_reset,
  output logic ce_pix,
  output logic ce_cpu_p,
  output logic ce_cpu_n,
  output logic ready
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES > HOLD_CYCLES ? SETTLE_CYCLES : HOLD_CYCLES);
  localparam int DIV_W = $clog2(CPU_DIV);

  logic lock_s, soft_s;

  sync2 u_sync_lock (.clk(clk_sys), .rst_n(rst_n), .d(pll_locked), .q(lock_s));
  sync2 u_sync_soft (.clk(clk_sys), .rst_n(rst_n), .d(soft_reset), .q(soft_s));

  clkseq_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             en_cur, en_nxt;

  assign en_cur = (state == HOLD) || (state == RUN);
  assign en_nxt = (state_nxt == HOLD) || (state_nxt == RUN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    div_nxt   = '0;
    if (!lock_s) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
        SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
        HOLD: begin
          // A held soft reset keeps restarting the hold window.
          if (soft_s) cnt_nxt = '0;
          else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end
        RUN: begin
          cnt_nxt = '0;
          if (soft_s) state_nxt = HOLD;
        end
        default: begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      endcase
    end
    // Divider free-runs across HOLD<->RUN so the cadence survives a soft reset.
    if (en_cur && en_nxt)
      div_nxt = (div_cnt == DIV_W'(CPU_DIV - 1)) ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      div_cnt    <= '0;
      core_reset <= 1'b1;
      ce_pix     <= 1'b0;
      ce_cpu_p   <= 1'b0;
      ce_cpu_n   <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      div_cnt    <= div_nxt;
      core_reset <= (state_nxt != RUN);
      ready      <= (state_nxt == RUN);
      ce_pix     <= en_nxt && ((32'(div_nxt) % PIX_DIV) == PIX_DIV - 1);
      ce_cpu_p   <= en_nxt && (div_nxt == DIV_W'(CPU_DIV / 2 - 1));
      ce_cpu_n   <= en_nxt && (div_nxt == DIV_W'(CPU_DIV - 1));
    end
  end

endmodule

// File: tb/tb_oric_clk_reset_seq.sv
// Scenario bench for oric_clk_reset_seq: release timing, enable cadence, lock
// glitches/loss, soft reset and async reset, with expectations queued up front.
module tb_oric_clk_reset_seq;

  localparam int REL = 2 + 1 + 1024 + 64;

  logic clk_sys = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, soft_reset = 1'b0;
  logic core_reset, ce_pix, ce_cpu_p, ce_cpu_n, ready;

  int checks = 0, failures = 0;
  int exp_q[$];

  always #5 clk_sys = ~clk_sys;

  oric_clk_reset_seq #(
    .PIX_DIV(4), .CPU_DIV(24), .SETTLE_CYCLES(1024), .HOLD_CYCLES(64)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .pll_locked(pll_locked), .soft_reset(soft_reset),
    .core_reset(core_reset), .ce_pix(ce_pix), .ce_cpu_p(ce_cpu_p), .ce_cpu_n(ce_cpu_n),
    .ready(ready)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Counts negedges from a (re)start point until core_reset falls; -1 on timeout.
  task automatic run_to_release(input int limit, output int rel, output int fpix,
                                output int fcp, output bit rdy);
    rel = -1; fpix = -1; fcp = -1; rdy = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk_sys);
      if (ce_pix && fpix < 0) fpix = n;
      if (ce_cpu_p && fcp < 0) fcp = n;
      if (!core_reset) begin
        rel = n;
        rdy = ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int rel, fp, fc, e;
    bit rdy;
    rst_n = 1'b0; pll_locked = 1'b1; soft_reset = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if ({core_reset, ready, ce_pix, ce_cpu_p, ce_cpu_n} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_values: got %b expected 10000",
               {core_reset, ready, ce_pix, ce_cpu_p, ce_cpu_n});
    end
    rst_n = 1'b1;
    exp_q.push_back(REL); exp_q.push_back(1030); exp_q.push_back(1038);
    run_to_release(3000, rel, fp, fc, rdy);
    e = exp_q.pop_front(); checks++;
    if (rel !== e) begin failures++; $display("FAIL release_latency: got %0d expected %0d", rel, e); end
    e = exp_q.pop_front(); checks++;
    if (fp !== e) begin failures++; $display("FAIL first_ce_pix: got %0d expected %0d", fp, e); end
    e = exp_q.pop_front(); checks++;
    if (fc !== e) begin failures++; $display("FAIL first_ce_cpu_p: got %0d expected %0d", fc, e); end
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL ready_at_release: got %0b expected 1", rdy); end
  endtask

  task automatic test_cadence();
    int np = 0, ncp = 0, ncn = 0, viol = 0, last_n = -1, e;
    exp_q.push_back(60); exp_q.push_back(10); exp_q.push_back(10); exp_q.push_back(0);
    for (int i = 0; i < 240; i++) begin
      @(negedge clk_sys);
      if (ce_pix) np++;
      if (ce_cpu_p) begin
        ncp++;
        if (last_n >= 0 && i - last_n != 12) viol++;
      end
      if (ce_cpu_n) begin
        ncn++;
        last_n = i;
        if (!ce_pix) viol++;
      end
    end
    e = exp_q.pop_front(); checks++;
    if (np !== e) begin failures++; $display("FAIL ce_pix_count: got %0d expected %0d", np, e); end
    e = exp_q.pop_front(); checks++;
    if (ncp !== e) begin failures++; $display("FAIL ce_cpu_p_count: got %0d expected %0d", ncp, e); end
    e = exp_q.pop_front(); checks++;
    if (ncn !== e) begin failures++; $display("FAIL ce_cpu_n_count: got %0d expected %0d", ncn, e); end
    e = exp_q.pop_front(); checks++;
    if (viol !== e) begin failures++; $display("FAIL cpu_phase_align: got %0d violations expected %0d", viol, e); end
  endtask

  task automatic test_lock_glitch();
    int rel, fp, fc, e;
    bit rdy;
    rst_n = 1'b0; pll_locked = 1'b1;
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (503) @(negedge clk_sys);   // SETTLE cnt is 500 here
    pll_locked = 1'b0;
    repeat (5) @(negedge clk_sys);
    pll_locked = 1'b1;
    exp_q.push_back(508 + REL); exp_q.push_back(1030);
    run_to_release(3000, rel, fp, fc, rdy);
    e = exp_q.pop_front(); checks++;
    if (508 + rel !== e) begin failures++; $display("FAIL glitch_release: got %0d expected %0d", 508 + rel, e); end
    e = exp_q.pop_front(); checks++;
    if (fp !== e) begin failures++; $display("FAIL glitch_first_pix: got %0d expected %0d", fp, e); end
  endtask

  task automatic test_lock_loss();
    int rel, fp, fc, e, bad = 0;
    bit rdy;
    pll_locked = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({core_reset, ready} !== 2'b01) begin
      failures++; $display("FAIL loss_m2_still_run: got %b expected 01", {core_reset, ready});
    end
    @(negedge clk_sys);
    exp_q.push_back(5'b10000);
    e = exp_q.pop_front(); checks++;
    if ({core_reset, ready, ce_pix, ce_cpu_p, ce_cpu_n} !== 5'(e)) begin
      failures++;
      $display("FAIL loss_m3_outputs: got %b expected %b",
               {core_reset, ready, ce_pix, ce_cpu_p, ce_cpu_n}, 5'(e));
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (!core_reset || ready || ce_pix || ce_cpu_p || ce_cpu_n) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL loss_quiet: got %0d active cycles expected 0", bad); end
    pll_locked = 1'b1;
    exp_q.push_back(REL);
    run_to_release(3000, rel, fp, fc, rdy);
    e = exp_q.pop_front(); checks++;
    if (rel !== e) begin failures++; $display("FAIL relock_release: got %0d expected %0d", rel, e); end
  endtask

  task automatic test_soft_reset();
    int rise = -1, fall = -1, last_p = -1, viol = 0, np = 0, e;
    exp_q.push_back(3); exp_q.push_back(166); exp_q.push_back(0); exp_q.push_back(75);
    soft_reset = 1'b1;
    for (int m = 1; m <= 300; m++) begin
      @(negedge clk_sys);
      if (core_reset && rise < 0) rise = m;
      if (!core_reset && rise >= 0 && fall < 0) fall = m;
      if (ce_pix) begin
        np++;
        if (last_p >= 0 && m - last_p != 4) viol++;
        last_p = m;
      end
      if (m == 100) soft_reset = 1'b0;
    end
    e = exp_q.pop_front(); checks++;
    if (rise !== e) begin failures++; $display("FAIL soft_rise: got %0d expected %0d", rise, e); end
    e = exp_q.pop_front(); checks++;
    if (fall !== e) begin failures++; $display("FAIL soft_fall: got %0d expected %0d", fall, e); end
    e = exp_q.pop_front(); checks++;
    if (viol !== e) begin failures++; $display("FAIL soft_pix_period: got %0d violations expected %0d", viol, e); end
    e = exp_q.pop_front(); checks++;
    if (np !== e) begin failures++; $display("FAIL soft_pix_count: got %0d expected %0d", np, e); end
  endtask

  task automatic test_rst_mid_hold();
    int rel, fp, fc, e;
    bit rdy;
    rst_n = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (1050) @(negedge clk_sys);  // div_cnt = 23 in HOLD
    checks++;
    if ({core_reset, ce_pix, ce_cpu_n} !== 3'b111) begin
      failures++; $display("FAIL hold_before_rst: got %b expected 111", {core_reset, ce_pix, ce_cpu_n});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({core_reset, ready, ce_pix, ce_cpu_p, ce_cpu_n} !== 5'b10000) begin
      failures++;
      $display("FAIL async_reset_values: got %b expected 10000",
               {core_reset, ready, ce_pix, ce_cpu_p, ce_cpu_n});
    end
    @(negedge clk_sys);
    rst_n = 1'b1;
    exp_q.push_back(REL);
    run_to_release(3000, rel, fp, fc, rdy);
    e = exp_q.pop_front(); checks++;
    if (rel !== e) begin failures++; $display("FAIL restart_release: got %0d expected %0d", rel, e); end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_lock_glitch();
    test_lock_loss();
    test_soft_reset();
    test_rst_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oric_clk_reset_seq.md
# oric_clk_reset_seq

Clock-enable and reset sequencer sitting directly downstream of the system PLL. Runs on the PLL's 24 MHz output and consumes the PLL's asynchronous `locked` flag. Outputs the core's synchronous reset and the single-cycle pixel (6 MHz) and CPU (1 MHz, two-phase) clock enables. Holds the core in reset until lock has been continuously stable for a settle period, and re-sequences on lock loss or an OSD soft-reset request.

## Interface
- `PIX_DIV`, 4: clk_sys cycles per ce_pix pulse.
- `CPU_DIV`, 24: clk_sys cycles per CPU cycle. Must be an even multiple of PIX_DIV.
- `SETTLE_CYCLES`, 1024: consecutive cycles lock_s must stay high before leaving SETTLE.
- `HOLD_CYCLES`, 64: cycles core_reset stays asserted with enables running.
- `clk_sys  in  1`: 24 MHz PLL output, sole clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `pll_locked  in  1`: PLL lock flag, asynchronous to clk_sys.
- `soft_reset  in  1`: OSD reset request, level, asynchronous.
- `core_reset  out  1`: active-high reset to the Oric core. Reset value 1.
- `ce_pix  out  1`: one-cycle pixel enable. Reset value 0.
- `ce_cpu_p  out  1`: one-cycle enable at PHI2 rise. Reset value 0.
- `ce_cpu_n  out  1`: one-cycle enable at PHI2 fall. Reset value 0.
- `ready  out  1`: high only in RUN. Reset value 0.

## Operation
- `pll_locked` and `soft_reset` each pass through a 2-flop synchronizer, giving lock_s and soft_s. Both synchronizer flops reset to 0.
- FSM states: WAIT_LOCK (reset state), SETTLE, HOLD, RUN.
  - WAIT_LOCK: when lock_s=1, go to SETTLE and clear cnt.
  - SETTLE: cnt increments each cycle. When cnt = SETTLE_CYCLES-1, go to HOLD, clear cnt and clear div_cnt.
  - HOLD: cnt increments. If soft_s=1, cnt reloads to 0 (hold extends while the request is held). When cnt = HOLD_CYCLES-1 and soft_s=0, go to RUN.
  - RUN: if soft_s=1, go to HOLD and clear cnt. div_cnt is not disturbed.
  - Any state with lock_s=0 goes to WAIT_LOCK. This has priority over all other transitions.
- Width rule: cnt is `$clog2(max(SETTLE_CYCLES, HOLD_CYCLES))` bits. It never wraps, because it is always reloaded on state change.
- Divider div_cnt (`$clog2(CPU_DIV)` bits):
  - Held at 0 in WAIT_LOCK and SETTLE.
  - Counts 0..CPU_DIV-1 and wraps to 0 in HOLD and RUN.
- Enables are high only in HOLD and RUN, in the cycle where div_cnt holds:
  - ce_pix: div_cnt mod PIX_DIV = PIX_DIV-1.
  - ce_cpu_p: div_cnt = CPU_DIV/2-1.
  - ce_cpu_n: div_cnt = CPU_DIV-1.
  - ce_cpu_n therefore always coincides with a ce_pix pulse.
- core_reset = 1 in WAIT_LOCK, SETTLE and HOLD; 0 in RUN. ready = RUN.
- All outputs are flops, decoded from the next state / next div_cnt so they align with the state and count above. No combinational paths from inputs to outputs.

## Timing
- Input synchronizer latency: 2 cycles.
- Minimum pll_locked rise to core_reset fall: 2 + 1 + SETTLE_CYCLES + HOLD_CYCLES cycles (1091 with defaults).
- pll_locked fall: core_reset rises, ready falls and all enables drop 3 cycles later (2 sync + 1 state register).
- A lock glitch shorter than one clk_sys may be missed; any glitch that is captured restarts from WAIT_LOCK.
- First cycle of HOLD has div_cnt=0. First ce_pix comes in the 4th HOLD cycle, first ce_cpu_p in the 12th.
- Soft reset from RUN: core_reset rises 3 cycles after soft_reset rises. The enable cadence continues unbroken.
- rst_n asserted mid-operation: all flops go asynchronously to reset values. Deassertion is synchronous to clk_sys only by virtue of the external reset synchronizer.

## Structure
- Package `oric_clk_pkg`:
  - state enum `clkseq_state_t` (WAIT_LOCK, SETTLE, HOLD, RUN).
  - default constants PIX_DIV_DEF=4, CPU_DIV_DEF=24.
- Sub-module `sync2`: 2-flop synchronizer with async active-low reset, instantiated twice.

## Test plan
- Reset release with pll_locked=1 from t0: core_reset falls exactly 1091 cycles after rst_n rises. ready rises in the same cycle. No enables are seen before SETTLE ends.
- In RUN, count over 240 cycles: 60 ce_pix, 10 ce_cpu_p, 10 ce_cpu_n. ce_cpu_p is 12 cycles after each ce_cpu_n. Every ce_cpu_n coincides with a ce_pix.
- pll_locked drops for 5 cycles during SETTLE at cnt=500: FSM returns to WAIT_LOCK, then SETTLE restarts from 0. Total release is delayed accordingly.
- Lock lost in RUN: 3 cycles later core_reset=1, ready=0 and all ce=0. Relock repeats the full 1091-cycle sequence.
- soft_reset held 100 cycles in RUN: core_reset rises after 3 cycles and falls 64 cycles after soft_s falls. The ce_pix period stays 4 throughout.
- rst_n pulsed low mid-HOLD: outputs immediately return to reset values (core_reset=1, others 0), then the sequence restarts.
